// File: rtl/idct_pkg.sv
// Shared types, DPRAM layout and the fixed-point cosine table for the 8x8 IDCT stage.
package idct_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P1_FLUSH,
    S_P2,
    S_P2_FLUSH,
    S_DONE
  } idct_state_t;

  localparam logic [8:0] LOADED_BLOCK_OFFSET = 9'd128;
  localparam logic [8:0] RESULT_OFFSET       = 9'd192;
  localparam logic [8:0] T_OFFSET            = 9'd256;
  localparam int unsigned C_FRAC_BITS        = 12;

  // Total pass scaling is 2^(2*C_FRAC_BITS); split as 2^8 after pass 1 and 2^16 after pass 2.
  localparam int unsigned P1_SHIFT = C_FRAC_BITS - 4;
  localparam int unsigned P2_SHIFT = C_FRAC_BITS + 4;

  // C[k][n] = round(4096 * c_k * cos((2n+1)k*pi/16)), folded onto one quarter wave.
  function automatic logic signed [15:0] c_coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]         m;
    logic [3:0]         idx;
    logic               neg;
    logic signed [15:0] mag;
    m = {1'b0, n, 1'b1} * {2'b00, k};
    if (m <= 5'd8) begin
      idx = m[3:0];
      neg = 1'b0;
    end else if (m <= 5'd16) begin
      idx = 4'(5'd16 - m);
      neg = 1'b1;
    end else if (m <= 5'd24) begin
      idx = 4'(m - 5'd16);
      neg = 1'b1;
    end else begin
      idx = 4'(5'd0 - m);
      neg = 1'b0;
    end
    case (idx)
      4'd0:    mag = 16'sd2048;
      4'd1:    mag = 16'sd2009;
      4'd2:    mag = 16'sd1892;
      4'd3:    mag = 16'sd1703;
      4'd4:    mag = 16'sd1448;
      4'd5:    mag = 16'sd1138;
      4'd6:    mag = 16'sd784;
      4'd7:    mag = 16'sd400;
      default: mag = 16'sd0;
    endcase
    if (k == 3'd0) begin
      return 16'sd1448;
    end
    return neg ? -mag : mag;
  endfunction

  // Read index bits: [8:6] = output row, [5:3] = output column, [2:0] = k.
  function automatic logic [8:0] rd_addr(input logic pass2, input logic [8:0] cnt);
    if (pass2) begin
      return T_OFFSET + {3'b000, cnt[2:0], cnt[5:3]};
    end
    return LOADED_BLOCK_OFFSET + {3'b000, cnt[8:6], cnt[2:0]};
  endfunction

endpackage

// File: rtl/idct_mac.sv
// Signed multiply-accumulate with per-pass output shaping (pass 1 shift, pass 2 shift + clip).
module idct_mac
  import idct_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic               pass2_i,
  input  logic signed [31:0] data_i,
  input  logic signed [15:0] coef_i,
  output logic        [31:0] result_o,
  output logic               clip_o
);

  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] prod;
  logic signed [31:0] sum;
  logic signed [31:0] shifted;
  logic        [7:0]  y;

  always_comb begin
    prod    = data_i * $signed({{16{coef_i[15]}}, coef_i});
    sum     = load_i ? prod : acc_q + prod;
    acc_d   = en_i ? sum : acc_q;
    shifted = pass2_i ? (sum >>> P2_SHIFT) : (sum >>> P1_SHIFT);
    if (shifted < 0) begin
      y = 8'd0;
    end else if (shifted > 255) begin
      y = 8'd255;
    end else begin
      y = shifted[7:0];
    end
    clip_o   = pass2_i && ((shifted < 0) || (shifted > 255));
    result_o = pass2_i ? {24'd0, y} : shifted;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/idct_block_compute.sv
// 8x8 two-pass IDCT over DPRAM: T = S*C, then Y = clip(C^T*T).
// Optional IDCT_CLIP_COUNT_EN adds Clip_count, the number of clipped pass-2 samples.
module idct_block_compute
  import idct_pkg::*;
(
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [8:0]  DPRAM_read_address,
  input  logic [31:0] DPRAM_read_data,
  output logic [8:0]  DPRAM_write_address,
  output logic [31:0] DPRAM_write_data,
  output logic        DPRAM_wen
`ifdef IDCT_CLIP_COUNT_EN
  ,
  output logic [6:0]  Clip_count
`endif
);

  idct_state_t state_q, state_d;
  logic [8:0]  rd_cnt_q, rd_cnt_d;
  logic [8:0]  rd_addr_q, rd_addr_d;
  logic        dat_vld_q, dat_vld_d;
  logic [8:0]  dat_cnt_q, dat_cnt_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef IDCT_CLIP_COUNT_EN
  logic [6:0]  clip_cnt_q, clip_cnt_d;
`endif

  logic               addr_vld;
  logic               pass2;
  logic [2:0]         dat_k;
  logic [8:0]         rd_cnt_inc;
  logic signed [31:0] mac_data;
  logic signed [15:0] mac_coef;
  logic [31:0]        mac_result;
  logic               mac_clip;

  // Data in the current cycle belongs to the pass named by the state, flush included.
  assign addr_vld   = (state_q == S_P1) || (state_q == S_P2);
  assign pass2      = (state_q == S_P2) || (state_q == S_P2_FLUSH);
  assign dat_k      = dat_cnt_q[2:0];
  assign rd_cnt_inc = rd_cnt_q + 9'd1;
  assign mac_data   = pass2 ? DPRAM_read_data
                            : {{16{DPRAM_read_data[15]}}, DPRAM_read_data[15:0]};
  assign mac_coef   = c_coef(dat_k, pass2 ? dat_cnt_q[8:6] : dat_cnt_q[5:3]);

  idct_mac u_mac (
    .clk_i    (Clock_50),
    .rst_i    (Reset),
    .en_i     (dat_vld_q),
    .load_i   (dat_k == 3'd0),
    .pass2_i  (pass2),
    .data_i   (mac_data),
    .coef_i   (mac_coef),
    .result_o (mac_result),
    .clip_o   (mac_clip)
  );

`ifndef IDCT_CLIP_COUNT_EN
  logic unused_clip;
  assign unused_clip = mac_clip;
`endif

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_addr_d = rd_addr_q;
    dat_vld_d = addr_vld;
    dat_cnt_d = rd_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wen_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef IDCT_CLIP_COUNT_EN
    clip_cnt_d = clip_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_P1;
          rd_cnt_d  = 9'd0;
          rd_addr_d = rd_addr(1'b0, 9'd0);
          busy_d    = 1'b1;
`ifdef IDCT_CLIP_COUNT_EN
          clip_cnt_d = 7'd0;
`endif
        end
      end
      S_P1: begin
        if (rd_cnt_q == 9'd511) begin
          state_d = S_P1_FLUSH;
        end else begin
          rd_cnt_d  = rd_cnt_inc;
          rd_addr_d = rd_addr(1'b0, rd_cnt_inc);
        end
      end
      S_P1_FLUSH: begin
        // Leave once the last T write is on the bus and no read data is pending.
        if (!dat_vld_q && wen_q) begin
          state_d   = S_P2;
          rd_cnt_d  = 9'd0;
          rd_addr_d = rd_addr(1'b1, 9'd0);
        end
      end
      S_P2: begin
        if (rd_cnt_q == 9'd511) begin
          state_d = S_P2_FLUSH;
        end else begin
          rd_cnt_d  = rd_cnt_inc;
          rd_addr_d = rd_addr(1'b1, rd_cnt_inc);
        end
      end
      S_P2_FLUSH: begin
        if (!dat_vld_q && wen_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // k=7 data completes an output: write it while the next output's reads continue.
    if (dat_vld_q && (dat_k == 3'd7)) begin
      wen_d     = 1'b1;
      wr_addr_d = (pass2 ? RESULT_OFFSET : T_OFFSET) + {3'b000, dat_cnt_q[8:3]};
      wr_data_d = mac_result;
`ifdef IDCT_CLIP_COUNT_EN
      if (mac_clip) begin
        clip_cnt_d = clip_cnt_q + 7'd1;
      end
`endif
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      dat_vld_q <= 1'b0;
      dat_cnt_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef IDCT_CLIP_COUNT_EN
      clip_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_addr_q <= rd_addr_d;
      dat_vld_q <= dat_vld_d;
      dat_cnt_q <= dat_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef IDCT_CLIP_COUNT_EN
      clip_cnt_q <= clip_cnt_d;
`endif
    end
  end

  assign Busy                = busy_q;
  assign Done                = done_q;
  assign DPRAM_read_address  = rd_addr_q;
  assign DPRAM_write_address = wr_addr_q;
  assign DPRAM_write_data    = wr_data_q;
  assign DPRAM_wen           = wen_q;
`ifdef IDCT_CLIP_COUNT_EN
  assign Clip_count          = clip_cnt_q;
`endif

endmodule
